// File: rtl/mips_pkg.sv
// Purpose: opcode, format and field-width definitions shared by the MIPS decode path.
// Latency: none; constants, types and one helper function only.
// Backpressure: not applicable.
package mips_pkg;

    localparam int OP_W    = 6;
    localparam int REG_W   = 5;
    localparam int SHAMT_W = 5;
    localparam int FUNCT_W = 6;
    localparam int FMT_W   = 2;
    localparam int IMM_W   = 16;
    localparam int JIDX_W  = 26;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;  // first of the branch/ALU-immediate block
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;  // last of the branch/ALU-immediate block
    localparam logic [OP_W-1:0] OP_LB    = 6'h20;  // first load/store opcode
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;  // last load/store opcode

    localparam logic [FMT_W-1:0] FMT_R   = 2'b00;
    localparam logic [FMT_W-1:0] FMT_I   = 2'b01;
    localparam logic [FMT_W-1:0] FMT_J   = 2'b10;
    localparam logic [FMT_W-1:0] FMT_ILL = 2'b11;

    // XLEN-independent part of a decoded entry.
    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   rd;
        logic [SHAMT_W-1:0] shamt;
        logic [FUNCT_W-1:0] funct;
        logic [FMT_W-1:0]   fmt;
        logic               illegal;
    } dec_fields_t;

    function automatic logic is_itype(input logic [OP_W-1:0] op);
        return ((op >= OP_BEQ) && (op <= OP_LUI)) || ((op >= OP_LB) && (op <= OP_SW));
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Purpose: split a MIPS instruction into fields, classify R/I/J, extend immediate, form jump target.
// Latency: combinational, zero cycles.
// Backpressure: none; the parent decides when the result is captured.
// Ports: instr/pc in; fields (op..illegal), imm_ext and jaddr out.
module instr_field_decode
    import mips_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int SIGN_EXT = 1
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output dec_fields_t     fields,
    output logic [XLEN-1:0] imm_ext,
    output logic [XLEN-1:0] jaddr
);

    logic [OP_W-1:0]  op;
    logic [IMM_W-1:0] imm;
    logic             pc_unused;

    assign op  = instr[31:26];
    assign imm = instr[15:0];
    // Only the region bits of the PC feed the jump target.
    assign pc_unused = ^pc[27:0];

    always_comb begin
        // Fields pass through raw; each format then zeroes what it does not own.
        fields.op      = op;
        fields.rs      = instr[25:21];
        fields.rt      = instr[20:16];
        fields.rd      = instr[15:11];
        fields.shamt   = instr[10:6];
        fields.funct   = instr[5:0];
        fields.fmt     = FMT_ILL;
        fields.illegal = 1'b1;
        imm_ext        = '0;
        jaddr          = '0;

        if (op == OP_RTYPE) begin
            fields.fmt     = FMT_R;
            fields.illegal = 1'b0;
        end else if ((op == OP_J) || (op == OP_JAL)) begin
            fields.fmt     = FMT_J;
            fields.illegal = 1'b0;
            fields.rs      = '0;
            fields.rt      = '0;
            fields.rd      = '0;
            fields.shamt   = '0;
            fields.funct   = '0;
            jaddr          = {pc[XLEN-1:28], instr[JIDX_W-1:0], 2'b00};
        end else if (is_itype(op)) begin
            fields.fmt     = FMT_I;
            fields.illegal = 1'b0;
            fields.rd      = '0;
            fields.shamt   = '0;
            fields.funct   = '0;
            if ((op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI)) begin
                // Logical immediates are always unsigned.
                imm_ext = XLEN'(imm);
            end else if (op == OP_LUI) begin
                imm_ext = XLEN'({imm, 16'h0000});
            end else if (SIGN_EXT != 0) begin
                imm_ext = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
            end else begin
                imm_ext = XLEN'(imm);
            end
        end
    end

endmodule

// File: rtl/instr_decode_pipe.sv
// Purpose: decode MIPS instructions at push and buffer them in a FIFO_DEPTH-entry queue.
// Latency: one cycle from an accepted input to out_valid when the queue was empty.
// Backpressure: in_ready drops when the queue is full; no pass-through, flush drops everything.
// Ports: clk/reset/flush; in_valid/in_ready/in_instr/in_pc; out_valid/out_ready with the
//        decoded head fields (op..illegal, imm_ext, jaddr); dec_count counts pops.
module instr_decode_pipe
    import mips_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int SIGN_EXT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [XLEN-1:0]     in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OP_W-1:0]     op,
    output logic [REG_W-1:0]    rs,
    output logic [REG_W-1:0]    rt,
    output logic [REG_W-1:0]    rd,
    output logic [SHAMT_W-1:0]  shamt,
    output logic [FUNCT_W-1:0]  funct,
    output logic [FMT_W-1:0]    fmt,
    output logic [XLEN-1:0]     imm_ext,
    output logic [XLEN-1:0]     jaddr,
    output logic                illegal,
    output logic [CNT_W-1:0]    dec_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0]    FULL_CNT = CW'(FIFO_DEPTH);

    dec_fields_t     dec_f;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_jaddr;

    dec_fields_t     mem_f     [FIFO_DEPTH];
    logic [XLEN-1:0] mem_imm   [FIFO_DEPTH];
    logic [XLEN-1:0] mem_jaddr [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             push, pop;
    dec_fields_t      head_f;

    instr_field_decode #(.XLEN(XLEN), .SIGN_EXT(SIGN_EXT)) u_dec (
        .instr   (in_instr),
        .pc      (in_pc),
        .fields  (dec_f),
        .imm_ext (dec_imm),
        .jaddr   (dec_jaddr)
    );

    assign in_ready  = (count < FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage needs no reset: the head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_f[wr_ptr]     <= dec_f;
            mem_imm[wr_ptr]   <= dec_imm;
            mem_jaddr[wr_ptr] <= dec_jaddr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dec_count <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap at FIFO_DEPTH, which need not be a power of two.
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
                dec_count <= dec_count + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_f  = out_valid ? mem_f[rd_ptr] : '0;
    assign imm_ext = out_valid ? mem_imm[rd_ptr] : '0;
    assign jaddr   = out_valid ? mem_jaddr[rd_ptr] : '0;
    assign op      = head_f.op;
    assign rs      = head_f.rs;
    assign rt      = head_f.rt;
    assign rd      = head_f.rd;
    assign shamt   = head_f.shamt;
    assign funct   = head_f.funct;
    assign fmt     = head_f.fmt;
    assign illegal = head_f.illegal;

endmodule
